// File: rtl/cdc_handshake_tx_pkg.sv
// Shared types and helpers for the source end of the 4-phase req/ack CDC.
package cdc_handshake_tx_pkg;

  // Handshake phases; the unused encoding 2'd3 recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_e;

  // Timeout counter width; at least one bit so a disabled timeout still elaborates.
  function automatic int unsigned cnt_width(input int unsigned timeout_cyc);
    if (timeout_cyc == 0) return 1;
    return $clog2(timeout_cyc + 1);
  endfunction

endpackage

// File: rtl/cdc_handshake_tx_if.sv
// Valid/ready word input plus req/ack crossing signals of the CDC transmitter.
interface cdc_handshake_tx_if #(
  parameter int DATA_W = 8
);
  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_data;
  logic              o_req;
  logic [DATA_W-1:0] o_data;
  logic              i_ack;
  logic              o_done;
  logic              o_timeout;
  logic              o_busy;

  // Transmitter side.
  modport slave (
    input  i_valid, i_data, i_ack,
    output o_ready, o_req, o_data, o_done, o_timeout, o_busy
  );

  // Word source / far-end side.
  modport master (
    output i_valid, i_data, i_ack,
    input  o_ready, o_req, o_data, o_done, o_timeout, o_busy
  );
endinterface

// File: rtl/cdc_handshake_tx_sync.sv
// Single-bit multi-flop synchroniser with asynchronous active-low reset.
module cdc_sync_ar #(
  parameter int STAGES = 3
) (
  input  logic clock,
  input  logic i_nrst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  // Shift the asynchronous input through the chain; last stage is the safe copy.
  always_ff @(posedge clock or negedge i_nrst) begin
    if (!i_nrst) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source end of a 4-phase req/ack clock-domain crossing: latches a word,
// raises a level request and waits for the synchronised acknowledge.
module cdc_handshake_tx
  import cdc_handshake_tx_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 3,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                clock,
  input  logic                i_nrst,
  cdc_handshake_tx_if.slave   bus
);

  localparam int unsigned      CNT_W    = cnt_width(TIMEOUT_CYC);
  localparam bit               TO_EN    = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYC - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e            r_state;
  logic              r_req;
  logic [DATA_W-1:0] r_data;
  logic              r_done;
  logic              r_timeout;
  logic              r_abort;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_ack_s;
  logic              w_ready;

  cdc_sync_ar #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clock  (clock),
    .i_nrst (i_nrst),
    .i_d    (bus.i_ack),
    .o_q    (w_ack_s)
  );

  // A spurious ack seen while idle blocks new words until it falls.
  assign w_ready = (r_state == IDLE) && !w_ack_s;

  // Handshake FSM with registered request, data, counter and pulse outputs.
  always_ff @(posedge clock or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state   <= IDLE;
      r_req     <= 1'b0;
      r_data    <= '0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_abort   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.i_valid && w_ready) begin
            r_data  <= bus.i_data;
            r_req   <= 1'b1;
            r_cnt   <= '0;
            r_state <= REQ;
          end
        end
        REQ: begin
          if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
          // Ack has priority over a timeout expiring in the same cycle.
          if (w_ack_s) begin
            r_req   <= 1'b0;
            r_state <= RELEASE;
          end else if (TO_EN && (r_cnt == CNT_LAST)) begin
            r_req     <= 1'b0;
            r_timeout <= 1'b1;
            r_abort   <= 1'b1;
            r_state   <= RELEASE;
          end
        end
        RELEASE: begin
          if (!w_ack_s) begin
            r_done  <= !r_abort;
            r_abort <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_abort <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_ready   = w_ready;
  assign bus.o_req     = r_req;
  assign bus.o_data    = r_data;
  assign bus.o_done    = r_done;
  assign bus.o_timeout = r_timeout;
  assign bus.o_busy    = (r_state != IDLE);

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Bench for cdc_handshake_tx: directed table, corner sequences, and a
// randomized far end checked every cycle against a behavioural model.
module tb_cdc_handshake_tx;

  localparam int DW = 8;
  localparam int S  = 3;
  localparam int T  = 16;

  logic clock = 1'b0;
  logic i_nrst;
  always #5 clock = ~clock;

  cdc_handshake_tx_if #(.DATA_W(DW)) ifc ();

  cdc_handshake_tx #(
    .DATA_W      (DW),
    .SYNC_STAGES (S),
    .TIMEOUT_CYC (T)
  ) dut (
    .clock  (clock),
    .i_nrst (i_nrst),
    .bus    (ifc)
  );

  logic man_ack = 1'b0;
  logic fe_ack  = 1'b0;
  logic fe_en   = 1'b0;
  assign ifc.i_ack = fe_en ? fe_ack : man_ack;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // ack_s is simply i_ack as sampled S clock edges ago.
  bit          ack_hist[$];
  bit          m_busy, m_req, m_abort, m_done, m_to;
  bit [DW-1:0] m_data;
  int          m_elapsed;
  bit          m_as;

  function automatic bit m_ack_s();
    if (ack_hist.size() < S) return 1'b0;
    return ack_hist[S-1];
  endfunction

  always @(posedge clock or negedge i_nrst) begin
    if (!i_nrst) begin
      m_busy = 0; m_req = 0; m_abort = 0; m_done = 0; m_to = 0;
      m_data = '0; m_elapsed = 0;
      ack_hist = {};
      repeat (S) ack_hist.push_back(1'b0);
    end else begin
      m_as   = m_ack_s();
      m_done = 0;
      m_to   = 0;
      if (!m_busy) begin
        if (ifc.i_valid && !m_as) begin
          m_data = ifc.i_data; m_req = 1; m_busy = 1; m_elapsed = 0;
        end
      end else if (m_req) begin
        m_elapsed++;
        if (m_as) m_req = 0;
        else if (m_elapsed == T) begin
          m_req = 0; m_to = 1; m_abort = 1;
        end
      end else if (!m_as) begin
        m_busy = 0; m_done = !m_abort; m_abort = 0;
      end
      ack_hist.push_front(ifc.i_ack);
      void'(ack_hist.pop_back());
    end
  end

  bit chk_en = 0;
  always @(negedge clock) begin
    if (chk_en && i_nrst)
      check("model_cmp",
            {ifc.o_ready, ifc.o_req, ifc.o_busy, ifc.o_done, ifc.o_timeout, ifc.o_data},
            {(!m_busy && !m_ack_s()), m_req, m_busy, m_done, m_to, m_data});
  end

  // Accept counter and data-hold check, observed purely from outputs.
  int          n_accept  = 0;
  logic        prev_busy = 1'b0;
  logic [DW-1:0] prev_data = '0;
  always @(negedge clock) begin
    if (i_nrst) begin
      if (ifc.o_busy && !prev_busy) n_accept++;
      if (ifc.o_busy && prev_busy) check("hold_data", ifc.o_data, prev_data);
    end
    prev_busy = ifc.o_busy;
    prev_data = ifc.o_data;
  end

  // ---------------- randomized far end ----------------
  int fe_cnt = 0;
  int fe_dly = 2;
  always @(negedge clock) begin
    if (!fe_en) begin
      fe_ack = 1'b0;
      fe_cnt = 0;
    end else if (ifc.o_req != fe_ack) begin
      if (fe_cnt >= fe_dly) begin
        fe_ack = ifc.o_req;
        fe_cnt = 0;
        fe_dly = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 4));
      end else begin
        fe_cnt++;
      end
    end else begin
      fe_cnt = 0;
    end
  end

  task automatic wait_ready(input int maxc);
    bit ok = 0;
    for (int i = 0; i < maxc; i++) begin
      if (ifc.o_ready) begin ok = 1; break; end
      @(negedge clock);
    end
    check("wait_ready", ok, 1'b1);
  endtask

  task automatic wait_idle(input int maxc);
    bit ok = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clock);
      if (!ifc.o_busy) begin ok = 1; break; end
    end
    check("wait_idle", ok, 1'b1);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          a;
    logic          ereq, ebusy, erdy, edone;
    logic [DW-1:0] edata;
  } vec_t;
  vec_t tbl[12];

  logic [DW-1:0] words[3];
  bit            got_done, saw_to;

  initial begin
    // Far end acks 2 cycles after req rises, drops 2 cycles after req falls.
    tbl[0]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5};
    tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5};
    tbl[3]  = '{1'b1, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5};

    i_nrst = 1'b1;
    ifc.i_valid = 1'b0;
    ifc.i_data  = '0;
    #1 i_nrst = 1'b0;
    #1;
    check("rst_ready",   ifc.o_ready,   1'b1);
    check("rst_req",     ifc.o_req,     1'b0);
    check("rst_busy",    ifc.o_busy,    1'b0);
    check("rst_data",    ifc.o_data,    '0);
    check("rst_pulses",  {ifc.o_done, ifc.o_timeout}, 2'b00);

    repeat (2) @(negedge clock);
    i_nrst = 1'b1;
    chk_en = 1;
    repeat (2) @(negedge clock);

    // 1: single transfer of 8'hA5, including an ignored word while busy.
    for (int i = 0; i < 12; i++) begin
      ifc.i_valid = tbl[i].v;
      ifc.i_data  = tbl[i].d;
      man_ack     = tbl[i].a;
      @(posedge clock);
      #1;
      check($sformatf("tbl_row%0d", i),
            {ifc.o_req, ifc.o_busy, ifc.o_ready, ifc.o_done, ifc.o_data},
            {tbl[i].ereq, tbl[i].ebusy, tbl[i].erdy, tbl[i].edone, tbl[i].edata});
      @(negedge clock);
    end

    // 2: back-to-back words with i_valid held.
    words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;
    fe_en = 1'b1;
    n_accept = 0;
    ifc.i_data  = words[0];
    ifc.i_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_ready(200);
      @(posedge clock);
      #1;
      check("t2_data", ifc.o_data, words[k]);
      if (k < 2) ifc.i_data = words[k+1];
      else       ifc.i_valid = 1'b0;
    end
    wait_idle(200);
    repeat (4) @(negedge clock);
    check("t2_accepts", n_accept, 3);

    // 3: timeout with ack never rising.
    fe_en   = 1'b0;
    man_ack = 1'b0;
    wait_ready(50);
    ifc.i_valid = 1'b1;
    ifc.i_data  = 8'h3C;
    @(posedge clock);
    #1 ifc.i_valid = 1'b0;
    check("t3_busy", ifc.o_busy, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      @(posedge clock);
      #1;
      if (k == 15) check("t3_req_held", ifc.o_req, 1'b1);
      if (k == 16) check("t3_req_fall_to", {ifc.o_req, ifc.o_timeout}, 2'b01);
    end
    @(posedge clock);
    #1;
    check("t3_after", {ifc.o_timeout, ifc.o_done, ifc.o_busy, ifc.o_ready}, 4'b0001);

    // 4: ack high across reset release blocks acceptance.
    @(negedge clock);
    man_ack = 1'b1;
    i_nrst  = 1'b0;
    repeat (2) @(negedge clock);
    i_nrst = 1'b1;
    repeat (S + 1) @(negedge clock);
    ifc.i_valid = 1'b1;
    ifc.i_data  = 8'h77;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("t4_blocked", {ifc.o_ready, ifc.o_busy}, 2'b00);
    end
    man_ack     = 1'b0;
    ifc.i_valid = 1'b0;
    for (int k = 1; k <= S; k++) begin
      @(negedge clock);
      check("t4_ready_return", ifc.o_ready, (k == S));
    end

    // 5: asynchronous reset while in REQ.
    wait_ready(50);
    ifc.i_valid = 1'b1;
    ifc.i_data  = 8'hC3;
    @(posedge clock);
    #1 ifc.i_valid = 1'b0;
    repeat (3) @(posedge clock);
    #3 i_nrst = 1'b0;
    #1;
    check("t5_async", {ifc.o_req, ifc.o_busy, ifc.o_data}, '0);
    @(negedge clock);
    i_nrst = 1'b1;
    @(negedge clock);
    check("t5_after", {ifc.o_ready, ifc.o_busy, ifc.o_data}, {1'b1, 1'b0, 8'h00});

    // 6: ack reaches the FSM on the exact timeout cycle.
    wait_ready(50);
    ifc.i_valid = 1'b1;
    ifc.i_data  = 8'hE6;
    @(posedge clock);
    #1 ifc.i_valid = 1'b0;
    repeat (12) @(posedge clock);
    @(negedge clock);
    man_ack = 1'b1;
    repeat (3) @(posedge clock);
    #1 check("t6_req_e15", ifc.o_req, 1'b1);
    @(posedge clock);
    #1 check("t6_e16", {ifc.o_req, ifc.o_timeout, ifc.o_busy}, 3'b001);
    @(negedge clock);
    man_ack  = 1'b0;
    got_done = 0;
    saw_to   = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1;
      if (ifc.o_timeout) saw_to = 1;
      if (ifc.o_done) begin got_done = 1; break; end
    end
    check("t6_done", got_done, 1'b1);
    check("t6_no_timeout", saw_to, 1'b0);

    // Randomized traffic against the model.
    @(negedge clock);
    fe_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      ifc.i_valid = ($urandom_range(0, 3) != 0);
      ifc.i_data  = DW'($urandom);
    end
    ifc.i_valid = 1'b0;
    repeat (60) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
